// File: rtl/request_unit_pkg.sv
// request_unit_pkg: shared state type for the memory request generator.
package request_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DREAD  = 2'b01,
    DWRITE = 2'b10,
    HALTED = 2'b11
  } reqstate_t;

endpackage

// File: rtl/request_unit.sv
// request_unit: memory request generator for the MIPS datapath.
// Keeps instruction fetch enabled until halt, and turns level load/store
// requests into registered data enables held until dHit.
// Optional macro REQUEST_UNIT_CHECK_EN compiles simulation-only assertions.
module request_unit
  import request_unit_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic halt,
  input  logic r_req,
  input  logic w_req,
  input  logic iHit,
  input  logic dHit,
  output logic iRen,
  output logic dRen,
  output logic dWen
);

  reqstate_t state;
  reqstate_t next_state;

  // iHit plays no part in sequencing; it is only observed by the checks.
  logic unused_ihit;
  assign unused_ihit = iHit;

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection and output decode.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (halt)       next_state = HALTED;
        else if (r_req) next_state = DREAD;
        else if (w_req) next_state = DWRITE;
      end
      DREAD:   if (dHit) next_state = IDLE;
      DWRITE:  if (dHit) next_state = IDLE;
      HALTED:  next_state = HALTED;
      default: next_state = IDLE;
    endcase

    dRen = (state == DREAD);
    dWen = (state == DWRITE);
    iRen = (state != HALTED) && !halt;
  end

`ifdef REQUEST_UNIT_CHECK_EN
  // Protocol sanity checks, evaluated on every active edge out of reset.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      assert (!(dRen && dWen))
        else $error("request_unit: dRen and dWen both high");
      assert (!(state == IDLE && r_req && w_req))
        else $error("request_unit: r_req and w_req both high in IDLE");
      assert (!(state == HALTED && iHit))
        else $error("request_unit: iHit while halted");
      assert (state inside {IDLE, DREAD, DWRITE, HALTED})
        else $error("request_unit: illegal state encoding");
    end
  end
`endif

endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed table-driven bench for request_unit.
module tb_request_unit;

  logic CLK;
  logic nRST;
  logic halt;
  logic r_req;
  logic w_req;
  logic iHit;
  logic dHit;
  logic iRen;
  logic dRen;
  logic dWen;

  int total;
  int bad;

  typedef struct {
    string name;
    logic  nrst;
    logic  halt;
    logic  r;
    logic  w;
    logic  dhit;
    logic  e_iren;
    logic  e_dren;
    logic  e_dwen;
  } vec_t;

  vec_t vecs[$];

  request_unit dut (
    .CLK  (CLK),
    .nRST (nRST),
    .halt (halt),
    .r_req(r_req),
    .w_req(w_req),
    .iHit (iHit),
    .dHit (dHit),
    .iRen (iRen),
    .dRen (dRen),
    .dWen (dWen)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic nr, input logic h, input logic r,
                     input logic w, input logic dh, input logic ei, input logic er,
                     input logic ew);
    vec_t v;
    v.name = nm; v.nrst = nr; v.halt = h; v.r = r; v.w = w; v.dhit = dh;
    v.e_iren = ei; v.e_dren = er; v.e_dwen = ew;
    vecs.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nRST = 1'b0; halt = 1'b0; r_req = 1'b0; w_req = 1'b0; iHit = 1'b0; dHit = 1'b0;

    //   name              nrst halt r  w  dhit   iren dren dwen
    add("reset",           0,   0,   0, 0, 0,     1,   0,   0);
    add("read_issue",      1,   0,   1, 0, 0,     1,   1,   0);
    add("read_hold1",      1,   0,   0, 0, 0,     1,   1,   0);
    add("read_hold2",      1,   0,   0, 0, 0,     1,   1,   0);
    add("read_done",       1,   0,   0, 0, 1,     1,   0,   0);
    add("write_issue",     1,   0,   0, 1, 0,     1,   0,   1);
    add("write_done",      1,   0,   0, 0, 1,     1,   0,   0);
    add("rw_prio",         1,   0,   1, 1, 0,     1,   1,   0);
    add("rw_prio_done",    1,   0,   0, 0, 1,     1,   0,   0);
    add("halt_prio",       1,   1,   1, 0, 0,     0,   0,   0);
    add("halted_sticky",   1,   0,   1, 0, 0,     0,   0,   0);
    add("halted_ign",      1,   0,   0, 1, 1,     0,   0,   0);
    add("reset_halted",    0,   0,   0, 0, 0,     1,   0,   0);
    add("read_again",      1,   0,   1, 0, 0,     1,   1,   0);
    add("halt_in_read",    1,   1,   0, 0, 0,     0,   1,   0);
    add("halt_read_done",  1,   1,   0, 0, 1,     0,   0,   0);
    add("halt_from_idle",  1,   1,   0, 0, 0,     0,   0,   0);
    add("halt_dropped",    1,   0,   0, 0, 0,     0,   0,   0);
    add("reset_w_halt",    0,   1,   0, 0, 0,     0,   0,   0);
    add("reset_no_halt",   0,   0,   0, 0, 0,     1,   0,   0);
    add("idle_dhit_ign",   1,   0,   0, 0, 1,     1,   0,   0);
    add("write_issue2",    1,   0,   0, 1, 0,     1,   0,   1);
    add("write_ign_req",   1,   0,   1, 1, 0,     1,   0,   1);
    add("write_done_lvl",  1,   0,   0, 1, 1,     1,   0,   0);
    add("write_reissue",   1,   0,   0, 1, 0,     1,   0,   1);
    add("reset_midwrite",  0,   0,   0, 1, 0,     1,   0,   0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      nRST  = vecs[i].nrst;
      halt  = vecs[i].halt;
      r_req = vecs[i].r;
      w_req = vecs[i].w;
      dHit  = vecs[i].dhit;
      @(posedge CLK);
      #1;
      chk({vecs[i].name, ".iRen"}, iRen, vecs[i].e_iren);
      chk({vecs[i].name, ".dRen"}, dRen, vecs[i].e_dren);
      chk({vecs[i].name, ".dWen"}, dWen, vecs[i].e_dwen);
    end

    // Combinational halt path in IDLE, no edge in between.
    @(negedge CLK);
    nRST = 1'b1; r_req = 1'b0; w_req = 1'b0; dHit = 1'b0; halt = 1'b1;
    #1;
    chk("comb_halt_idle.iRen", iRen, 1'b0);
    halt = 1'b0;
    #1;
    chk("comb_unhalt_idle.iRen", iRen, 1'b1);

    // Halt raised mid-read: iRen drops before any edge, dRen holds.
    r_req = 1'b1;
    @(posedge CLK);
    #1;
    chk("seq_read.dRen", dRen, 1'b1);
    @(negedge CLK);
    r_req = 1'b0; halt = 1'b1;
    #1;
    chk("seq_halt_read.iRen", iRen, 1'b0);
    chk("seq_halt_read.dRen", dRen, 1'b1);
    @(negedge CLK);
    dHit = 1'b1;
    @(posedge CLK);
    #1;
    chk("seq_read_done.dRen", dRen, 1'b0);
    @(negedge CLK);
    dHit = 1'b0; halt = 1'b0;
    #1;
    chk("seq_idle_before_halt.iRen", iRen, 1'b1);
    halt = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    halt = 1'b0;
    #1;
    chk("seq_halted.iRen", iRen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
